// File: rtl/mem_access_stage.sv
// mem_access_stage: data-memory access stage after the execute ALU.
// Non-memory ops and misaligned LW/SW retire one cycle after acceptance.
// Aligned LW/SW run a waitrequest handshake against the data port and
// retire one cycle after the transfer completes. Requests held by
// waitrequest for too long are dropped and reported as a bus error.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_reg,
  input  logic        reg_write,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_write,
  output logic        addr_error,
  output logic        bus_error,
  output logic        stall
);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [7:0]  wait_cnt, wait_cnt_next;
  logic [4:0]  pend_reg, pend_reg_next;

  logic [31:0] mem_address_next, mem_writedata_next;
  logic        mem_read_next, mem_write_next;
  logic [3:0]  mem_byteenable_next;
  logic        wb_valid_next, wb_write_next;
  logic [31:0] wb_data_next;
  logic [4:0]  wb_reg_next;
  logic        addr_error_next, bus_error_next;

  logic        is_mem_op, misaligned;

  // Handshake signals decoded from the state register only.
  assign in_ready   = (state == IDLE);
  assign stall      = in_valid & ~in_ready;
  assign is_mem_op  = (opcode == OP_LW) || (opcode == OP_SW);
  assign misaligned = (alu_out[1:0] != 2'b00);

  // Next-state and next-output decode for every registered output.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; an unassigned path would infer a latch.
    state_next          = state;
    wait_cnt_next       = wait_cnt;
    pend_reg_next       = pend_reg;
    mem_address_next    = mem_address;
    mem_writedata_next  = mem_writedata;
    mem_read_next       = mem_read;
    mem_write_next      = mem_write;
    mem_byteenable_next = mem_byteenable;
    wb_valid_next       = 1'b0;
    wb_data_next        = wb_data;
    wb_reg_next         = wb_reg;
    wb_write_next       = wb_write;
    addr_error_next     = 1'b0;
    bus_error_next      = 1'b0;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem_op) begin
            wb_valid_next = 1'b1;
            wb_data_next  = alu_out;
            wb_reg_next   = dest_reg;
            wb_write_next = reg_write;
          end else if (misaligned) begin
            wb_valid_next   = 1'b1;
            wb_data_next    = alu_out;
            wb_reg_next     = dest_reg;
            wb_write_next   = 1'b0;
            addr_error_next = 1'b1;
          end else begin
            mem_address_next    = alu_out;
            mem_byteenable_next = 4'b1111;
            pend_reg_next       = dest_reg;
            wait_cnt_next       = 8'd0;
            if (opcode == OP_LW) begin
              mem_read_next = 1'b1;
              state_next    = READ;
            end else begin
              mem_write_next     = 1'b1;
              mem_writedata_next = store_data;
              state_next         = WRITE;
            end
          end
        end
      end

      READ, WRITE: begin
        if (!mem_waitrequest || (wait_cnt == TIMEOUT)) begin
          // Transfer finished or abandoned: release the bus and retire.
          mem_read_next       = 1'b0;
          mem_write_next      = 1'b0;
          mem_byteenable_next = 4'b0000;
          state_next          = IDLE;
          wb_valid_next       = 1'b1;
          wb_reg_next         = pend_reg;
          if (mem_waitrequest) begin
            wb_write_next  = 1'b0;
            bus_error_next = 1'b1;
          end else begin
            wb_write_next = (state == READ);
            if (state == READ) begin
              wb_data_next = mem_readdata;
            end
          end
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wait_cnt       <= 8'd0;
      pend_reg       <= 5'd0;
      mem_address    <= 32'd0;
      mem_writedata  <= 32'd0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byteenable <= 4'b0000;
      wb_valid       <= 1'b0;
      wb_data        <= 32'd0;
      wb_reg         <= 5'd0;
      wb_write       <= 1'b0;
      addr_error     <= 1'b0;
      bus_error      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state          <= state_next;
      wait_cnt       <= wait_cnt_next;
      pend_reg       <= pend_reg_next;
      mem_address    <= mem_address_next;
      mem_writedata  <= mem_writedata_next;
      mem_read       <= mem_read_next;
      mem_write      <= mem_write_next;
      mem_byteenable <= mem_byteenable_next;
      wb_valid       <= wb_valid_next;
      wb_data        <= wb_data_next;
      wb_reg         <= wb_reg_next;
      wb_write       <= wb_write_next;
      addr_error     <= addr_error_next;
      bus_error      <= bus_error_next;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed scenarios plus randomized
// instruction streams checked against a transaction-level model with a
// word-addressed memory image.
module tb_mem_access_stage;

  localparam int unsigned TIMEOUT = 4;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = '0;
  logic [31:0] alu_out = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  dest_reg = '0;
  logic        reg_write = 1'b0;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_readdata = '0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_write;
  logic        addr_error;
  logic        bus_error;
  logic        stall;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem_model [logic [31:0]];

  mem_access_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .alu_out(alu_out), .store_data(store_data),
    .dest_reg(dest_reg), .reg_write(reg_write), .mem_address(mem_address),
    .mem_read(mem_read), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_waitrequest(mem_waitrequest),
    .mem_readdata(mem_readdata), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_reg(wb_reg), .wb_write(wb_write), .addr_error(addr_error),
    .bus_error(bus_error), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Run one instruction through the stage and check its whole life.
  // nwait = number of cycles the memory holds waitrequest high.
  task automatic exec(input logic [5:0] op, input logic [31:0] alu,
                      input logic [31:0] sd, input logic [4:0] dst,
                      input logic rw, input int nwait, input bit hold_next,
                      input string tag);
    bit          is_ld, is_st, mis, timed_out;
    int          req_cycles;
    logic [31:0] rd_val;
    is_ld     = (op == OP_LW);
    is_st     = (op == OP_SW);
    mis       = (is_ld || is_st) && (alu[1:0] != 2'b00);
    timed_out = (nwait > int'(TIMEOUT));
    req_cycles = timed_out ? int'(TIMEOUT) + 1 : nwait + 1;
    rd_val    = mem_rd(alu);

    @(negedge clk);
    n_cmp++;
    if ({in_ready, wb_valid, mem_read, mem_write} !== 4'b1000) begin
      n_err++;
      $display("FAIL %s idle_before: rdy/wbv/rd/wr=%b expected 1000", tag,
               {in_ready, wb_valid, mem_read, mem_write});
    end
    in_valid = 1'b1; opcode = op; alu_out = alu; store_data = sd;
    dest_reg = dst; reg_write = rw;
    @(posedge clk);
    #1;
    in_valid = 1'b0; opcode = 6'($urandom); alu_out = $urandom;
    store_data = $urandom; dest_reg = 5'($urandom); reg_write = 1'($urandom);

    if (!(is_ld || is_st) || mis) begin
      @(negedge clk);
      n_cmp++;
      if ({wb_valid, wb_write, addr_error, bus_error, mem_read, mem_write, mem_byteenable}
          !== {1'b1, (!mis) & rw, mis, 1'b0, 1'b0, 1'b0, 4'b0000}) begin
        n_err++;
        $display("FAIL %s retire_flags: got %b expected %b", tag,
                 {wb_valid, wb_write, addr_error, bus_error, mem_read, mem_write, mem_byteenable},
                 {1'b1, (!mis) & rw, mis, 1'b0, 1'b0, 1'b0, 4'b0000});
      end
      if (!mis) begin
        n_cmp++;
        if ({wb_data, wb_reg} !== {alu, dst}) begin
          n_err++;
          $display("FAIL %s wb_data_reg: got %h/%0d expected %h/%0d", tag,
                   wb_data, wb_reg, alu, dst);
        end
      end
      return;
    end

    for (int c = 0; c < req_cycles; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_read, mem_write, mem_byteenable, in_ready, wb_valid, mem_address}
          !== {is_ld, is_st, 4'b1111, 1'b0, 1'b0, alu}) begin
        n_err++;
        $display("FAIL %s request_c%0d: rd/wr/be/rdy/wbv=%b addr=%h expected %b addr=%h",
                 tag, c, {mem_read, mem_write, mem_byteenable, in_ready, wb_valid},
                 mem_address, {is_ld, is_st, 4'b1111, 1'b0, 1'b0}, alu);
      end
      if (is_st) begin
        n_cmp++;
        if (mem_writedata !== sd) begin
          n_err++;
          $display("FAIL %s writedata_c%0d: got %h expected %h", tag, c, mem_writedata, sd);
        end
      end
      if (hold_next) begin
        in_valid = 1'b1; opcode = 6'b001001; alu_out = 32'h0BAD_0BAD;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin
          n_err++;
          $display("FAIL %s stall_c%0d: got %b expected 1", tag, c, stall);
        end
      end
      mem_waitrequest = (c < nwait);
      mem_readdata    = (c < nwait) ? $urandom : rd_val;
    end

    @(negedge clk);
    if (hold_next) begin
      n_cmp++;
      if (stall !== 1'b0) begin
        n_err++;
        $display("FAIL %s stall_release: got %b expected 0", tag, stall);
      end
      in_valid = 1'b0;
    end
    mem_waitrequest = 1'b0;
    mem_readdata    = $urandom;
    n_cmp++;
    if ({wb_valid, wb_write, addr_error, bus_error, mem_read, mem_write, mem_byteenable, in_ready}
        !== {1'b1, is_ld & !timed_out, 1'b0, timed_out, 1'b0, 1'b0, 4'b0000, 1'b1}) begin
      n_err++;
      $display("FAIL %s mem_retire: got %b expected %b", tag,
               {wb_valid, wb_write, addr_error, bus_error, mem_read, mem_write, mem_byteenable, in_ready},
               {1'b1, is_ld & !timed_out, 1'b0, timed_out, 1'b0, 1'b0, 4'b0000, 1'b1});
    end
    if (is_ld && !timed_out) begin
      n_cmp++;
      if ({wb_data, wb_reg} !== {rd_val, dst}) begin
        n_err++;
        $display("FAIL %s load_data: got %h/%0d expected %h/%0d", tag,
                 wb_data, wb_reg, rd_val, dst);
      end
    end
    if (is_st && !timed_out) mem_model[alu] = sd;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, wb_valid, wb_write, addr_error, bus_error, mem_read, mem_write,
         mem_byteenable, stall} !== 12'b1000_0000_0000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 100000000000",
               {in_ready, wb_valid, wb_write, addr_error, bus_error, mem_read, mem_write,
                mem_byteenable, stall});
    end
    n_cmp++;
    if ({mem_address, mem_writedata, wb_data, wb_reg} !== '0) begin
      n_err++;
      $display("FAIL reset_data: addr=%h wdata=%h wbdata=%h wbreg=%0d expected all 0",
               mem_address, mem_writedata, wb_data, wb_reg);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    in_valid = 1'b1; opcode = 6'b001001; alu_out = 32'h10; dest_reg = 5'd4; reg_write = 1'b1;
    @(posedge clk);
    #1;
    opcode = 6'b000000; alu_out = 32'hFFFF_FFFF; dest_reg = 5'd7; reg_write = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({wb_valid, wb_write, stall, wb_data, wb_reg} !== {1'b1, 1'b1, 1'b0, 32'h10, 5'd4}) begin
      n_err++;
      $display("FAIL b2b_first: v/w/stall=%b data=%h reg=%0d expected 110 00000010 4",
               {wb_valid, wb_write, stall}, wb_data, wb_reg);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({wb_valid, wb_write, stall, wb_data, wb_reg} !== {1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 5'd7}) begin
      n_err++;
      $display("FAIL b2b_second: v/w/stall=%b data=%h reg=%0d expected 110 ffffffff 7",
               {wb_valid, wb_write, stall}, wb_data, wb_reg);
    end
    @(negedge clk);
    n_cmp++;
    if ({wb_valid, wb_data} !== {1'b0, 32'hFFFF_FFFF}) begin
      n_err++;
      $display("FAIL b2b_pulse_hold: v=%b data=%h expected 0 ffffffff", wb_valid, wb_data);
    end
  endtask

  task automatic test_load;
    mem_model[32'h100] = 32'hDEAD_BEEF;
    exec(OP_LW, 32'h100, 32'h0, 5'd9, 1'b1, 0, 1'b0, "lw_nowait");
  endtask

  task automatic test_store_wait;
    exec(OP_SW, 32'h200, 32'h1234_5678, 5'd2, 1'b0, 3, 1'b1, "sw_wait3");
    exec(OP_LW, 32'h200, 32'h0, 5'd11, 1'b1, 1, 1'b0, "lw_after_sw");
  endtask

  task automatic test_misaligned;
    exec(OP_LW, 32'h102, 32'h0, 5'd5, 1'b1, 0, 1'b0, "lw_misaligned");
    exec(OP_SW, 32'h203, 32'hCAFE_F00D, 5'd6, 1'b0, 0, 1'b0, "sw_misaligned");
  endtask

  task automatic test_timeout;
    exec(OP_LW, 32'h180, 32'h0, 5'd12, 1'b1, 1000, 1'b0, "lw_timeout");
    exec(OP_SW, 32'h184, 32'h5555_AAAA, 5'd0, 1'b0, int'(TIMEOUT), 1'b0, "sw_edge_no_timeout");
    exec(OP_SW, 32'h188, 32'h7777_8888, 5'd0, 1'b0, int'(TIMEOUT) + 1, 1'b0, "sw_timeout");
    exec(OP_LW, 32'h188, 32'h0, 5'd13, 1'b1, 0, 1'b0, "lw_after_dropped_sw");
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk);
    in_valid = 1'b1; opcode = OP_LW; alu_out = 32'h400; dest_reg = 5'd3; reg_write = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mem_waitrequest = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mem_read !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre: mem_read=%b expected 1", mem_read);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mem_read, mem_write, mem_byteenable, wb_valid, in_ready} !== 8'b0000_0001) begin
      n_err++;
      $display("FAIL rst_mid_async: rd/wr/be/wbv/rdy=%b expected 00000001",
               {mem_read, mem_write, mem_byteenable, wb_valid, in_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_waitrequest = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({wb_valid, mem_read} !== 2'b00) begin
        n_err++;
        $display("FAIL rst_mid_no_retire_%0d: wbv/rd=%b expected 00", i, {wb_valid, mem_read});
      end
    end
    exec(OP_LW, 32'h400, 32'h0, 5'd3, 1'b1, 2, 1'b0, "lw_after_reset");
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      int          kind;
      logic [5:0]  op;
      logic [31:0] a;
      kind = int'($urandom_range(0, 2));
      a = 32'h300 + (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (kind == 0) begin
        op = 6'($urandom);
        if (op == OP_LW || op == OP_SW) op = 6'b100001;
        a = $urandom;
      end else begin
        op = (kind == 1) ? OP_LW : OP_SW;
      end
      exec(op, a, $urandom, 5'($urandom), 1'($urandom), int'($urandom_range(0, 6)),
           1'($urandom), $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load();
    test_store_wait();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Data-memory access stage sitting directly downstream of the execute ALU in the harvard 5-instruction core. It consumes the ALU result as an effective address (LW/SW) or as a result to forward (ADDU/ADDIU/JR). It runs a wait-state-tolerant read/write handshake against the data memory port and hands one retired result per instruction to writeback. The upstream stage is stalled while a memory access is outstanding.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles a memory request may be held by waitrequest before being aborted; range 1..255.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream instruction present this cycle.
- in_ready  out  1  stage can accept an instruction this cycle.
- opcode  in  6  instruction opcode; 100011 = LW, 101011 = SW, all others are non-memory.
- alu_out  in  32  ALU result: effective address for LW/SW, result otherwise.
- store_data  in  32  rt register value, used by SW.
- dest_reg  in  5  writeback register index.
- reg_write  in  1  instruction writes a register (honoured for non-memory ops).
- mem_address  out  32  word-aligned data address.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- mem_writedata  out  32  store data.
- mem_byteenable  out  4  always 4'b1111 while a request is active, else 0.
- mem_waitrequest  in  1  memory not ready; request must be held unchanged.
- mem_readdata  in  32  valid in the cycle mem_read=1 and mem_waitrequest=0.
- wb_valid  out  1  one-cycle pulse: an instruction retired.
- wb_data  out  32  writeback value.
- wb_reg  out  5  writeback register index.
- wb_write  out  1  register file write enable, qualified by wb_valid.
- addr_error  out  1  one-cycle pulse with wb_valid: misaligned LW/SW.
- bus_error  out  1  one-cycle pulse with wb_valid: memory timeout.
- stall  out  1  in_valid & ~in_ready (combinational).

## Operation
- FSM states: IDLE, READ, WRITE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid:
  - Non-memory op: next cycle wb_valid=1, wb_data=alu_out, wb_reg=dest_reg, wb_write=reg_write. Stay in IDLE.
  - LW/SW with alu_out[1:0]≠0: no memory access. Next cycle wb_valid=1, wb_write=0, addr_error=1. Stay in IDLE.
  - Aligned LW: register mem_address=alu_out and dest_reg, then go to READ.
  - Aligned SW: register mem_address=alu_out and mem_writedata=store_data, then go to WRITE.
- READ/WRITE: in_ready=0. mem_read (or mem_write) and mem_byteenable=1111 are held high, with address and data stable.
  - A transfer completes in the first cycle with mem_waitrequest=0.
  - LW completion: capture mem_readdata. Next cycle wb_valid=1, wb_data=captured data, wb_write=1. Return to IDLE.
  - SW completion: next cycle wb_valid=1, wb_write=0. Return to IDLE.
- Timeout: an 8-bit wait counter clears on entry to READ/WRITE and increments each cycle waitrequest=1.
  - When the counter equals TIMEOUT_CYCLES with waitrequest still 1, the request is dropped.
  - Next cycle: wb_valid=1, wb_write=0, bus_error=1. Return to IDLE.
- Instructions arriving while in READ/WRITE are not consumed. Upstream holds them (stall=1).

## Timing
- Reset values: all outputs 0 except in_ready=1. FSM in IDLE, counter 0.
- Reset asserted mid-access drops mem_read/mem_write immediately (asynchronous). The pending retirement is discarded.
- All outputs except stall and in_ready are registered. in_ready is decoded from the state register.
- Latency from the accept edge to wb_valid:
  - Non-memory op or misaligned access: 1 cycle, back-to-back throughput 1 per cycle.
  - LW/SW: 2 + N cycles, where N = number of waitrequest cycles.
- The request becomes visible in the cycle after the accept edge. With waitrequest=0 it completes in that same cycle.
- wb_valid is never high for two consecutive cycles for the same instruction. wb_* hold their last value when wb_valid=0.
- addr_error and bus_error are never both high.

## Test plan
- Back-to-back ADDIU (alu_out=0x10) then ADDU (alu_out=0xFFFFFFFF), reg_write=1 -> wb_valid high two consecutive cycles with those data values, stall=0 throughout.
- LW at 0x100 with waitrequest=0 and readdata=0xDEADBEEF -> mem_read one cycle at address 0x100, wb_valid one cycle later with wb_data=0xDEADBEEF, wb_write=1.
- SW at 0x200 with store_data=0x12345678 and 3 waitrequest cycles -> mem_write held 4 cycles with stable address and data, stall=1 while a next instruction waits, then wb_valid with wb_write=0.
- LW at 0x102 -> no mem_read, addr_error=1 with wb_valid, wb_write=0.
- TIMEOUT_CYCLES=4, waitrequest stuck at 1 -> mem_read drops after the counter reaches 4, bus_error pulse, in_ready=1 again.
- rst_n low during a READ with waitrequest=1 -> mem_read=0 immediately, no wb_valid, next LW after reset completes normally.
